// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if
// Groups the EX-stage signals shared between the execute pipeline and the
// HI/LO multiply/divide unit.
//   alucontrolE  : decoded ALU control of the EX instruction (pipeline -> unit)
//   srcaE/srcbE  : rs/rt operands (pipeline -> unit)
//   flushE       : cancels the EX instruction (pipeline -> unit)
//   stallE       : divide in progress, freeze F/D/E (unit -> pipeline)
//   hiloresultE  : MFHI/MFLO read data (unit -> pipeline)
//   hi_o/lo_o    : architectural HI/LO registers (unit -> pipeline)
interface hilo_muldiv_if;
  logic [4:0]  alucontrolE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stallE;
  logic [31:0] hiloresultE;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  // Execute pipeline side
  modport master (
    output alucontrolE, srcaE, srcbE, flushE,
    input  stallE, hiloresultE, hi_o, lo_o
  );

  // HI/LO unit side
  modport slave (
    input  alucontrolE, srcaE, srcbE, flushE,
    output stallE, hiloresultE, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// EX-stage HI/LO unit: single-cycle MULT/MULTU, MTHI/MTLO writes, MFHI/MFLO
// reads and a 32-iteration restoring divider for DIV/DIVU that holds stallE
// while it runs.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : hilo_muldiv_if.slave (control, operands, flush, stall, read data, HI/LO)
// The *_CONTROL encodings below mirror the ALU decoder's defines.
module hilo_muldiv #(
  parameter int DIV_ITERS = 32
) (
  input logic           clk,
  input logic           rst,
  hilo_muldiv_if.slave  bus
);

  localparam logic [4:0] MULT_CONTROL  = 5'b01000;
  localparam logic [4:0] MULTU_CONTROL = 5'b01001;
  localparam logic [4:0] DIV_CONTROL   = 5'b01010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b01011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b01100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b01101;
  localparam logic [4:0] MFHI_CONTROL  = 5'b01110;
  localparam logic [4:0] MFLO_CONTROL  = 5'b01111;

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] rem, quo, dsr;
  logic        q_neg, r_neg;

  logic        hi_we, lo_we, div_load;
  logic [31:0] hi_d, lo_d;

  // Operand preparation shared by multiply and divide
  logic        is_div, signed_div, div_start, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_s, prod_u;

  assign is_div     = (bus.alucontrolE == DIV_CONTROL) || (bus.alucontrolE == DIVU_CONTROL);
  assign signed_div = (bus.alucontrolE == DIV_CONTROL);
  assign div_start  = is_div && (bus.srcbE != 32'd0) && !bus.flushE;
  assign a_neg      = signed_div & bus.srcaE[31];
  assign b_neg      = signed_div & bus.srcbE[31];
  assign a_mag      = a_neg ? (32'd0 - bus.srcaE) : bus.srcaE;
  assign b_mag      = b_neg ? (32'd0 - bus.srcbE) : bus.srcbE;
  // Low 64 bits of a product of sign-extended operands equal the signed product
  assign prod_s     = {{32{bus.srcaE[31]}}, bus.srcaE} * {{32{bus.srcbE[31]}}, bus.srcbE};
  assign prod_u     = {32'd0, bus.srcaE} * {32'd0, bus.srcbE};

  // One restoring step: the shifted partial remainder needs 33 bits so the
  // borrow of the trial subtraction is visible.
  logic [32:0] shifted, trial;
  logic        no_borrow;
  logic [31:0] quo_fix, rem_fix;

  assign shifted   = {rem, quo[31]};
  assign trial     = shifted - {1'b0, dsr};
  assign no_borrow = ~trial[32];
  assign quo_fix   = q_neg ? (32'd0 - quo) : quo;
  assign rem_fix   = r_neg ? (32'd0 - rem) : rem;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a flush abandons any divide in flight
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (div_start) state_next = DIV_RUN;
        else           state_next = IDLE;
      end
      DIV_RUN: begin
        if (bus.flushE)             state_next = IDLE;
        else if (cnt == LAST_ITER)  state_next = DIV_DONE;
        else                        state_next = DIV_RUN;
      end
      DIV_DONE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic: stall request and HI/LO write enables/data
  always_comb begin
    bus.stallE = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = 32'd0;
    lo_d       = 32'd0;
    div_load   = 1'b0;
    case (state)
      IDLE: begin
        case (bus.alucontrolE)
          MULT_CONTROL: begin
            hi_we = !bus.flushE;
            lo_we = !bus.flushE;
            hi_d  = prod_s[63:32];
            lo_d  = prod_s[31:0];
          end
          MULTU_CONTROL: begin
            hi_we = !bus.flushE;
            lo_we = !bus.flushE;
            hi_d  = prod_u[63:32];
            lo_d  = prod_u[31:0];
          end
          MTHI_CONTROL: begin
            hi_we = !bus.flushE;
            hi_d  = bus.srcaE;
          end
          MTLO_CONTROL: begin
            lo_we = !bus.flushE;
            lo_d  = bus.srcaE;
          end
          DIV_CONTROL, DIVU_CONTROL: begin
            // Divide by zero leaves HI/LO untouched and never stalls
            bus.stallE = (bus.srcbE != 32'd0);
            div_load   = div_start;
          end
          default: begin
            bus.stallE = 1'b0;
          end
        endcase
      end
      DIV_RUN: begin
        bus.stallE = 1'b1;
      end
      DIV_DONE: begin
        hi_we = !bus.flushE;
        lo_we = !bus.flushE;
        hi_d  = rem_fix;
        lo_d  = quo_fix;
      end
      default: begin
        bus.stallE = 1'b0;
      end
    endcase
  end

  // HI/LO registers and divider datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= 32'd0;
      lo    <= 32'd0;
      rem   <= 32'd0;
      quo   <= 32'd0;
      dsr   <= 32'd0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      cnt   <= 5'd0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
      if (div_load) begin
        rem   <= 32'd0;
        quo   <= a_mag;
        dsr   <= b_mag;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        cnt   <= 5'd0;
      end else if (state == DIV_RUN) begin
        // Without a subtraction shifted < divisor, so bit 32 is already zero
        rem <= no_borrow ? trial[31:0] : shifted[31:0];
        quo <= {quo[30:0], no_borrow};
        cnt <= cnt + 5'd1;
      end
    end
  end

  // Read port and register outputs
  always_comb begin
    case (bus.alucontrolE)
      MFHI_CONTROL: bus.hiloresultE = hi;
      MFLO_CONTROL: bus.hiloresultE = lo;
      default:      bus.hiloresultE = 32'd0;
    endcase
  end

  assign bus.hi_o = hi;
  assign bus.lo_o = lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv
// Directed bench for hilo_muldiv: a vector table for single-cycle operations,
// then hand-written sequences for divides, flush of a running divide and
// asynchronous reset mid-divide. Inputs change on the falling edge; outputs
// are sampled 1 ns later (combinational) or 1 ns after the rising edge.
module tb_hilo_muldiv;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_MULTU = 5'b01001;
  localparam logic [4:0] OP_DIV   = 5'b01010;
  localparam logic [4:0] OP_DIVU  = 5'b01011;
  localparam logic [4:0] OP_MTHI  = 5'b01100;
  localparam logic [4:0] OP_MTLO  = 5'b01101;
  localparam logic [4:0] OP_MFHI  = 5'b01110;
  localparam logic [4:0] OP_MFLO  = 5'b01111;

  logic clk;
  logic rst;
  hilo_muldiv_if bus();

  hilo_muldiv #(.DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        exp_stall;
    logic [31:0] exp_res;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[18];

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    bus.alucontrolE = op;
    bus.srcaE       = a;
    bus.srcbE       = b;
    bus.flushE      = fl;
  endtask

  // Issue a divide, count stall cycles (bounded), then check HI/LO in C34
  task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    @(negedge clk);
    drive(op, a, b, 1'b0);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.stallE) break;
      n++;
      @(negedge clk);
    end
    check({name, " stall_cycles"}, 32'(n), 32'd33);
    @(posedge clk);
    #1;
    check({name, " hi"}, bus.hi_o, exp_hi);
    check({name, " lo"}, bus.lo_o, exp_lo);
    @(negedge clk);
    drive(OP_NOP, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    //               op        a              b              fl    stall res            hi             lo
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        1'b0, 1'b0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{OP_MFHI,  32'd0,        32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 1'b0, 32'd0,        32'h00000001, 32'hFFFFFFFE};
    vecs[3]  = '{OP_MFLO,  32'd0,        32'd0,        1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE};
    vecs[4]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'd0,        32'h3FFFFFFF, 32'h00000001};
    vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'd0,        32'h40000000, 32'h00000000};
    vecs[6]  = '{OP_MULT,  32'h80000000, 32'd1,        1'b0, 1'b0, 32'd0,        32'hFFFFFFFF, 32'h80000000};
    vecs[7]  = '{OP_MULTU, 32'h80000000, 32'd2,        1'b0, 1'b0, 32'd0,        32'h00000001, 32'h00000000};
    vecs[8]  = '{OP_MTHI,  32'h00001234, 32'd0,        1'b0, 1'b0, 32'd0,        32'h00001234, 32'h00000000};
    vecs[9]  = '{OP_MTLO,  32'h00005678, 32'd0,        1'b0, 1'b0, 32'd0,        32'h00001234, 32'h00005678};
    vecs[10] = '{OP_DIV,   32'd55,       32'd0,        1'b0, 1'b0, 32'd0,        32'h00001234, 32'h00005678};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 32'd0,        32'h00001234, 32'h00005678};
    vecs[12] = '{OP_MULT,  32'd3,        32'd3,        1'b1, 1'b0, 32'd0,        32'h00001234, 32'h00005678};
    vecs[13] = '{OP_DIV,   32'd10,       32'd2,        1'b1, 1'b1, 32'd0,        32'h00001234, 32'h00005678};
    vecs[14] = '{OP_MTLO,  32'd9,        32'd0,        1'b0, 1'b0, 32'd0,        32'h00001234, 32'h00000009};
    vecs[15] = '{OP_MFHI,  32'd0,        32'd0,        1'b0, 1'b0, 32'h00001234, 32'h00001234, 32'h00000009};
    vecs[16] = '{OP_MFLO,  32'd0,        32'd0,        1'b0, 1'b0, 32'h00000009, 32'h00001234, 32'h00000009};
    vecs[17] = '{OP_NOP,   32'hDEADBEEF, 32'd7,        1'b0, 1'b0, 32'd0,        32'h00001234, 32'h00000009};

    rst = 1'b1;
    drive(OP_NOP, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset stall", 32'(bus.stallE), 32'd0);
    check("reset hi", bus.hi_o, 32'd0);
    check("reset lo", bus.lo_o, 32'd0);
    check("reset result", bus.hiloresultE, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle operations from the table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].flush);
      #1;
      check($sformatf("vec%0d stall", i), 32'(bus.stallE), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d result", i), bus.hiloresultE, vecs[i].exp_res);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d hi", i), bus.hi_o, vecs[i].exp_hi);
      check($sformatf("vec%0d lo", i), bus.lo_o, vecs[i].exp_lo);
    end
    @(negedge clk);
    drive(OP_NOP, 32'd0, 32'd0, 1'b0);

    // Divides
    run_div("div -7/2",      OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_div("divu 100/7",    OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
    run_div("div ovf",       OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    run_div("div 7/-2",      OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    run_div("divu big/16",   OP_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF);

    // Flush in C10 of a DIVU: next cycle is IDLE, an MTHI there is accepted
    @(negedge clk);
    drive(OP_MTLO, 32'h00005678, 32'd0, 1'b0);
    @(negedge clk);
    drive(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    bus.flushE = 1'b1;
    #1;
    check("flush C10 stall", 32'(bus.stallE), 32'd1);
    @(negedge clk);
    drive(OP_MTHI, 32'h0000AAAA, 32'd0, 1'b0);
    #1;
    check("flush C11 stall", 32'(bus.stallE), 32'd0);
    check("flush C11 lo", bus.lo_o, 32'h00005678);
    @(posedge clk);
    #1;
    check("flush mthi hi", bus.hi_o, 32'h0000AAAA);
    @(negedge clk);
    drive(OP_NOP, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 40; i++) @(negedge clk);
    #1;
    check("flush late stall", 32'(bus.stallE), 32'd0);
    check("flush late hi", bus.hi_o, 32'h0000AAAA);
    check("flush late lo", bus.lo_o, 32'h00005678);

    // Asynchronous reset in C20 of a divide
    @(negedge clk);
    drive(OP_DIV, 32'd12345, 32'd17, 1'b0);
    for (int i = 0; i < 20; i++) @(negedge clk);
    #1;
    check("rst C20 stall before", 32'(bus.stallE), 32'd1);
    drive(OP_NOP, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst async stall", 32'(bus.stallE), 32'd0);
    check("rst async hi", bus.hi_o, 32'd0);
    check("rst async lo", bus.lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    #1;
    check("rst late hi", bus.hi_o, 32'd0);
    check("rst late lo", bus.lo_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Execute-stage consumer of the ALU decoder's `alucontrol` codes for the HI/LO class: `MULT`, `MULTU`, `DIV`, `DIVU`, `MTHI`, `MTLO`, `MFHI` and `MFLO` (the `*_CONTROL` macros in `defines2.vh`). It owns the architectural HI/LO registers. Multiplies complete in one cycle. Divides use an iterative restoring divider, and the block holds the pipeline stall request while a divide runs. It sits beside the ALU in EX; its read result is muxed into the EX result on MFHI/MFLO.

## Interface
Parameters:
- `DIV_ITERS`, default 32: divider iterations, one quotient bit per cycle. Fixed at 32 for the 32-bit datapath.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alucontrolE` in 5: decoded ALU control of the instruction in EX.
- `srcaE` in 32: rs operand (dividend, multiplicand, or MTHI/MTLO data).
- `srcbE` in 32: rt operand (divisor, multiplier).
- `flushE` in 1: cancels the EX instruction; suppresses all HI/LO writes.
- `stallE` out 1: high while a divide occupies EX; the hazard unit freezes F/D/E on it.
- `hiloresultE` out 32: HI when `MFHI_CONTROL`, LO when `MFLO_CONTROL`, else 0 (combinational).
- `hi_o` out 32: current HI register.
- `lo_o` out 32: current LO register.

## Operation
- States are IDLE, DIV_RUN and DIV_DONE; a 5-bit iteration counter `cnt` runs inside DIV_RUN.
- **IDLE, `flushE`=0**, by `alucontrolE`:
  - `MULT`: {HI,LO} ← signed 64-bit product of srcaE×srcbE at the edge.
  - `MULTU`: {HI,LO} ← unsigned 64-bit product at the edge.
  - `MTHI`: HI ← srcaE. `MTLO`: LO ← srcaE.
  - `DIV`/`DIVU` with srcbE ≠ 0: `stallE`=1 combinationally in this cycle. Capture |dividend|, |divisor| (raw values for DIVU), quotient sign = sign(a)^sign(b), remainder sign = sign(a). Go to DIV_RUN with `cnt`=0.
  - `DIV`/`DIVU` with srcbE = 0: no stall; HI and LO are left unchanged (decided behaviour).
  - Any other code: no action.
- **DIV_RUN**:
  - `stallE`=1.
  - Each cycle performs one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient LSB on no-borrow.
  - `cnt` increments each cycle; at `cnt`=31 the next state is DIV_DONE.
- **DIV_DONE**:
  - `stallE`=0.
  - At the edge: LO ← sign-corrected quotient, HI ← sign-corrected remainder; go to IDLE.
  - `alucontrolE` is ignored in this state, because it still holds the same divide.
- **Signed fix-up**: negate in two's complement, with the 32-bit result truncated. 0x80000000 / −1 gives LO=0x80000000, HI=0.
- **`flushE`=1**:
  - In IDLE, no write occurs.
  - In DIV_RUN or DIV_DONE, the state returns to IDLE at the next edge with no HI/LO write.
  - `stallE` stays combinationally as defined for the current state during the flush cycle; the hazard unit gives the flush priority.
- `hiloresultE` reads the registers directly. No bypass is needed, because all writes commit at the end of EX.
- Only one writer fires per cycle, since EX holds a single instruction.

## Timing
- **Reset** (asynchronous): HI=0, LO=0, state=IDLE, `cnt`=0, internal divider registers 0. `stallE`=0 and `hiloresultE`=0, with an IDLE control code assumed during reset.
- **MULT/MULTU/MTHI/MTLO**: latency 1; the result is visible on `hi_o`/`lo_o` in the cycle after issue.
- **DIV/DIVU** (divisor ≠ 0), counting the issue cycle as C0:
  - `stallE`=1 in C0..C32 (33 cycles).
  - DIV_DONE is cycle C33, with `stallE`=0.
  - HI/LO are updated and visible in C34.
- **MFHI/MFLO** issued in the cycle after a write reads the new value; there are no interlock cycles.
- **Reset asserted mid-divide**: immediate return to IDLE, `stallE`=0, HI=LO=0.

## Test plan
- **Signed multiply**: MULT with srcaE=0xFFFFFFFD (−3), srcbE=5 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1; `stallE` never rises.
- **Unsigned multiply, then read back**: MULTU 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE. A following MFLO gives `hiloresultE`=0xFFFFFFFE.
- **Signed divide**: DIV −7 (0xFFFFFFF9) / 2 → `stallE` high exactly 33 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Unsigned divide and overflow case**:
  - DIVU 100/7 → LO=14, HI=2.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero**: preload HI=0x1234 and LO=0x5678 via MTHI/MTLO; DIV x/0 → `stallE` stays 0, HI/LO unchanged.
- **Cancel paths**:
  - Pulse `flushE` in cycle C10 of a DIVU → IDLE next cycle, `stallE`=0, HI/LO unchanged.
  - Assert `rst` in C20 of another divide → HI=LO=0, `stallE`=0 without waiting for a clock edge.
